// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions used by fetch and decode: datapath width, the NOP
// encoding, and the fetch FSM state encoding.
package instr_fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: holds the instruction handed to decode.
// Priority is reset, flush, load, then consume-or-hold.
module if_id_reg
    import instr_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            hold,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (!hold) begin
            // Decode took the instruction (or there was none): show a bubble.
            valid <= 1'b0;
            instr <= NOP;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding-request fetch FSM and pc,
// feeding decode through the if_id_reg pipeline register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            icache_req,
    output logic [XLEN-1:0] icache_addr,
    input  logic            icache_ready,
    input  logic            icache_rvalid,
    input  logic [XLEN-1:0] icache_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output fetch_state_t    fsm_state
);

    // Request channel: a request transfers on a cycle where icache_req and
    // icache_ready are both high; icache_addr is stable while icache_req is
    // high, and the response comes back as a one-cycle icache_rvalid pulse.

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic            handshake;
    logic            load;

    assign handshake   = icache_req && icache_ready;
    assign icache_addr = pc;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (handshake) begin
                    state_next = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (icache_rvalid) begin
                    state_next = FETCH;
                end else if (redirect) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (icache_rvalid) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        icache_req = 1'b0;
        load       = 1'b0;
        case (state)
            FETCH:   icache_req = !rst && (!if_valid || !id_stall);
            WAIT:    load       = icache_rvalid && !redirect;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= align_word(redirect_pc);
        end else if (load) begin
            pc <= pc + 32'd4;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .flush      (redirect),
        .hold       (id_stall),
        .load_pc    (pc),
        .load_instr (icache_rdata),
        .valid      (if_valid),
        .pc         (if_pc),
        .instr      (if_instr)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural cache with programmable grants and
// latency, plus a scoreboard of expected request addresses and decoded words.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_req;
    logic [31:0]  icache_addr;
    logic         icache_ready;
    logic         icache_rvalid;
    logic [31:0]  icache_rdata;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         id_stall;
    logic         if_valid;
    logic [31:0]  if_pc;
    logic [31:0]  if_instr;
    fetch_state_t fsm_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_out_q[$];

    int          grants = 0;
    int          lat    = 1;
    logic        pend   = 1'b0;
    int          cnt    = 0;
    logic [31:0] pend_addr;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_ready  (icache_ready),
        .icache_rvalid (icache_rvalid),
        .icache_rdata  (icache_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .id_stall      (id_stall),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit delivered);
        exp_addr_q.push_back(a);
        if (delivered) exp_out_q.push_back({a, mem_word(a)});
    endtask

    task automatic wait_state(input fetch_state_t s, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (fsm_state == s) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL %s actual=timeout required=state_%0d", name, s);
                break;
            end
        end
        step();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (if_valid) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL %s actual=timeout required=if_valid", name);
                break;
            end
        end
        step();
    endtask

    task automatic drain(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (exp_addr_q.size() == 0 && exp_out_q.size() == 0 && !pend && !icache_rvalid) break;
            n++;
            if (n > 60) begin
                checks++;
                failures++;
                $display("FAIL %s actual=pending_%0d_%0d required=empty", name,
                         exp_addr_q.size(), exp_out_q.size());
                exp_addr_q.delete();
                exp_out_q.delete();
                break;
            end
        end
        step();
    endtask

    // ---------------- cache model ----------------
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        logic        rst_s;
        icache_ready  = 1'b0;
        icache_rvalid = 1'b0;
        icache_rdata  = '0;
        forever begin
            @(negedge clk);
            acc      = icache_req && icache_ready;
            acc_addr = icache_addr;
            rst_s    = rst;
            @(posedge clk);
            #1;
            icache_rvalid = 1'b0;
            if (rst_s) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    grants--;
                    pend      = 1'b1;
                    cnt       = lat;
                    pend_addr = acc_addr;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        icache_rvalid = 1'b1;
                        icache_rdata  = mem_word(pend_addr);
                        pend          = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
            icache_ready = (grants > 0);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (icache_req && icache_ready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_addr actual=%h required=no_request", icache_addr);
                end else begin
                    check32("req_addr", icache_addr, exp_addr_q.pop_front());
                end
            end
            if (if_valid && !id_stall && !redirect) begin
                if (exp_out_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL if_out actual=%h required=no_instruction", {if_pc, if_instr});
                end else begin
                    check64("if_out", {if_pc, if_instr}, exp_out_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        step();
        step();
        @(negedge clk);
        check32("rst_req",   {31'd0, icache_req}, 32'd0);
        check32("rst_addr",  icache_addr, 32'h0000_0000);
        check32("rst_valid", {31'd0, if_valid}, 32'd0);
        check32("rst_pc",    if_pc, 32'd0);
        check32("rst_instr", if_instr, NOP);
        check32("rst_state", {30'd0, fsm_state}, {30'd0, FETCH});
        step();

        // Back-to-back fetch with a 1-cycle cache
        rst    = 1'b0;
        grants = 3;
        expect_fetch(32'h0, 1'b1);
        expect_fetch(32'h4, 1'b1);
        expect_fetch(32'h8, 1'b1);
        drain("seq_drain");

        // Decode stall holds the IF/ID register and blocks new requests
        id_stall = 1'b1;
        grants   = 1;
        expect_fetch(32'hC, 1'b1);
        wait_valid("stall_valid");
        grants = 1;
        expect_fetch(32'h10, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check32("stall_valid", {31'd0, if_valid}, 32'd1);
            check32("stall_pc",    if_pc, 32'hC);
            check32("stall_instr", if_instr, mem_word(32'hC));
            check32("stall_req",   {31'd0, icache_req}, 32'd0);
            step();
        end
        id_stall = 1'b0;
        @(negedge clk);
        check32("unstall_req",  {31'd0, icache_req}, 32'd1);
        check32("unstall_addr", icache_addr, 32'h10);
        step();
        drain("stall_drain");

        // Redirect while waiting: response dropped, low pc bits cleared
        lat    = 3;
        grants = 1;
        expect_fetch(32'h14, 1'b0);
        wait_state(WAIT, "wait_redir_wait");
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check32("wr_state", {30'd0, fsm_state}, {30'd0, DRAIN});
        check32("wr_valid", {31'd0, if_valid}, 32'd0);
        check32("wr_instr", if_instr, NOP);
        step();
        @(negedge clk);
        check32("wr_fetch_state", {30'd0, fsm_state}, {30'd0, FETCH});
        check32("wr_next_addr", icache_addr, 32'h100);
        step();
        lat    = 1;
        grants = 1;
        expect_fetch(32'h100, 1'b1);
        drain("wr_drain");

        // Redirect in the same cycle as the response
        lat    = 2;
        grants = 1;
        expect_fetch(32'h104, 1'b0);
        wait_state(WAIT, "coinc_wait");
        redirect    = 1'b1;
        redirect_pc = 32'h2000_0042;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check32("co_state", {30'd0, fsm_state}, {30'd0, FETCH});
        check32("co_valid", {31'd0, if_valid}, 32'd0);
        check32("co_instr", if_instr, NOP);
        check32("co_addr",  icache_addr, 32'h2000_0040);
        step();
        lat    = 1;
        grants = 1;
        expect_fetch(32'h2000_0040, 1'b1);
        drain("co_drain");

        // pc wraps from the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check32("wrap_addr",  icache_addr, 32'hFFFF_FFFC);
        check32("wrap_state", {30'd0, fsm_state}, {30'd0, FETCH});
        step();
        grants = 2;
        expect_fetch(32'hFFFF_FFFC, 1'b1);
        expect_fetch(32'h0000_0000, 1'b1);
        drain("wrap_drain");

        // Reset while draining abandons the outstanding request
        lat    = 6;
        grants = 1;
        expect_fetch(32'h4, 1'b0);
        wait_state(WAIT, "rd_wait");
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check32("rd_state", {30'd0, fsm_state}, {30'd0, DRAIN});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check32("rd_addr",  icache_addr, 32'h0000_0000);
        check32("rd_valid", {31'd0, if_valid}, 32'd0);
        check32("rd_instr", if_instr, NOP);
        check32("rd_fsm",   {30'd0, fsm_state}, {30'd0, FETCH});
        step();
        lat    = 1;
        grants = 1;
        expect_fetch(32'h0, 1'b1);
        drain("rd_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  meaning reset, synchronous and active-high.
REQ-004 SHALL have icache_req  output  1  meaning a fetch request is presented to the instruction cache.
REQ-005 SHALL have icache_addr  output  32  meaning the fetch address, valid while icache_req=1.
REQ-006 SHALL have icache_ready  input  1  meaning the cache accepts the request this cycle.
REQ-007 SHALL have icache_rvalid  input  1  meaning fetch response data is valid this cycle.
REQ-008 SHALL have icache_rdata  input  32  meaning the fetched instruction word.
REQ-009 SHALL have redirect  input  1  meaning a taken branch/jump; flush and refetch.
REQ-010 SHALL have redirect_pc  input  32  meaning the new fetch address, valid with redirect.
REQ-011 SHALL have id_stall  input  1  meaning decode cannot consume if_instr this cycle.
REQ-012 SHALL have if_valid  output  1  meaning if_instr/if_pc hold a live instruction for the decoder/controller.
REQ-013 SHALL have if_pc  output  32  meaning the address of if_instr.
REQ-014 SHALL have if_instr  output  32  meaning the instruction word fed to decode.

Function
REQ-015 SHALL implement FSM states FETCH, WAIT and DRAIN, with at most one outstanding cache request.
REQ-016 In FETCH, SHALL drive icache_req=1 with icache_addr=pc only when (!if_valid || !id_stall); otherwise icache_req=0.
REQ-017 FETCH: a handshake (icache_req && icache_ready) without redirect SHALL go to WAIT.
REQ-018 FETCH + redirect without handshake: pc<=redirect_pc, stay FETCH; with handshake: pc<=redirect_pc, go to DRAIN.
REQ-019 WAIT + rvalid without redirect: if_instr<=icache_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, go to FETCH.
REQ-020 WAIT + rvalid + redirect in the same cycle: discard the data, pc<=redirect_pc, go to FETCH.
REQ-021 WAIT + redirect without rvalid: pc<=redirect_pc, go to DRAIN.
REQ-022 DRAIN: discard the response when rvalid arrives, then go to FETCH; a further redirect in DRAIN SHALL update pc and stay in DRAIN until rvalid.
REQ-023 Any redirect SHALL clear if_valid and set if_instr to NOP 32'h0000_0013 in the same edge; redirect has priority over id_stall.
REQ-024 if_valid && !id_stall with no new load SHALL clear if_valid and set if_instr to NOP.
REQ-025 if_valid && id_stall with no redirect SHALL hold if_valid, if_pc and if_instr unchanged.
REQ-026 pc+4 SHALL wrap modulo 2^32.
REQ-027 redirect_pc[1:0] SHALL be ignored; the loaded pc has bits [1:0] forced to 0.
REQ-028 Latency: the response cycle SHALL load if_instr at the next edge, so it is visible one cycle after rvalid; the minimum cost is 2 cycles per instruction with a 1-cycle-ready cache.

Reset
REQ-029 On rst=1 at a clock edge, SHALL set pc=RESET_PC, state=FETCH, if_valid=0, if_pc=0 and if_instr=NOP, overriding all other inputs.
REQ-030 icache_req SHALL be 0 during the reset cycle.
REQ-031 Reset mid-WAIT or mid-DRAIN SHALL abandon the outstanding request; the cache shares rst and drops it, so no stale rvalid is expected.

Structure
REQ-032 The NOP constant, the FSM state encoding, and the 32-bit XLEN width SHALL reside in the shared CPU package used by decode.
REQ-033 SHALL instantiate one sub-module, if_id_reg, holding if_valid, if_pc and if_instr with load, flush and hold controls; the FSM and pc stay in instr_fetch.

Verification
REQ-034 Reset, then a cache with ready=1 and rvalid 1 cycle later -> addresses 0x0, 0x4, 0x8 requested; if_valid pulses with matching if_pc.
REQ-035 id_stall=1 held 3 cycles with if_valid=1 -> if_instr/if_pc stable, no new icache_req; the next fetch is issued the cycle id_stall drops.
REQ-036 redirect=1 with redirect_pc=0x103 while in WAIT -> if_valid=0, if_instr=0x13, old response discarded, next icache_addr=0x100.
REQ-037 redirect coincident with rvalid -> data dropped, FSM in FETCH, next icache_addr=redirect_pc.
REQ-038 pc=0xFFFF_FFFC fetch completes -> next icache_addr=0x0000_0000.
REQ-039 rst asserted in DRAIN -> the next cycle shows icache_addr=RESET_PC, if_valid=0, if_instr=0x13.
